// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage next-PC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fetch_ctrl_pkg;

    // Default PC targets; the top exposes these as overridable parameters
    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;

    // Stall counter sticks here instead of wrapping
    localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_HALT = 2'd3
    } state_e;

    // Winning next-PC source, lowest to highest priority
    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_JUMP   = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_TRAP   = 2'd3
    } redir_sel_e;

    // Pipeline bubbles requested by a redirect
    typedef struct packed {
        logic id_ex;
        logic if_id;
    } flush_t;

    localparam flush_t FLUSH_NONE  = '{id_ex: 1'b0, if_id: 1'b0};
    localparam flush_t FLUSH_IF_ID = '{id_ex: 1'b0, if_id: 1'b1};
    localparam flush_t FLUSH_ALL   = '{id_ex: 1'b1, if_id: 1'b1};

    // EX-stage causes (trap, branch) kill both younger stages; an ID jump
    // only kills the wrong-path instruction sitting in IF/ID.
    function automatic flush_t sel_flush(input redir_sel_e sel);
        flush_t f;
        case (sel)
            SEL_TRAP:   f = FLUSH_ALL;
            SEL_BRANCH: f = FLUSH_ALL;
            SEL_JUMP:   f = FLUSH_IF_ID;
            default:    f = FLUSH_NONE;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/fetch_ctrl_redirect_arb.sv
// Priority select of next-PC target and flush set: trap > branch > jump > pc+4.
// Latency: purely combinational, zero cycles.
// Backpressure: load-use hazard masks the ID jump only; EX causes override it.
module fetch_ctrl_redirect_arb
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEF
) (
    input  logic        i_trap,
    input  logic        i_ex_br_taken,
    input  logic [31:0] i_ex_br_target,
    input  logic        i_id_jump,
    input  logic [31:0] i_id_jump_target,
    input  logic        i_load_use_hazard,
    input  logic [31:0] i_pc4,
    output redir_sel_e  o_sel,
    output logic [31:0] o_target,
    output flush_t      o_flush,
    output logic        o_lu_stall
);

    logic w_jump_ok;

    // The jal sits in ID alongside the stalled consumer, so it waits too
    assign w_jump_ok = i_id_jump && !i_load_use_hazard;

    // Pick the highest-priority source, its target and the bubbles it needs
    always_comb begin
        o_sel    = SEL_SEQ;
        o_target = i_pc4;
        if (i_trap) begin
            o_sel    = SEL_TRAP;
            o_target = TRAP_VECTOR;
        end else if (i_ex_br_taken) begin
            o_sel    = SEL_BRANCH;
            o_target = i_ex_br_target;
        end else if (w_jump_ok) begin
            o_sel    = SEL_JUMP;
            o_target = i_id_jump_target;
        end
        o_flush    = sel_flush(o_sel);
        // A stall only matters when nothing from EX is squashing the consumer
        o_lu_stall = i_load_use_hazard && !i_trap && !i_ex_br_taken;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Next-PC sequencer: drives PC enable/next value and IF/ID, ID/EX enable/flush.
// Latency: outputs combinational from state and inputs; PC moves on the next edge.
// Backpressure: holds PC while imem is not ready or on load-use; parks redirects in pend_pc.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
    parameter logic [31:0] TRAP_VECTOR  = TRAP_VECTOR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc4,
    input  logic        i_imem_ready,
    input  logic        i_load_use_hazard,
    input  logic        i_ex_br_taken,
    input  logic [31:0] i_ex_br_target,
    input  logic        i_id_jump,
    input  logic [31:0] i_id_jump_target,
    input  logic        i_trap,
    input  logic        i_halt_req,
    output logic        o_pc_en,
    output logic [31:0] o_npc,
    output logic        o_if_id_en,
    output logic        o_if_id_flush,
    output logic        o_id_ex_flush,
    output logic        o_halted,
    output logic [31:0] o_stall_cycles
);

    state_e      r_state;
    logic [31:0] r_pend_pc;
    logic [31:0] r_stall_cycles;

    state_e      w_state_nxt;
    logic        w_pend_ld;
    logic [31:0] w_pend_nxt;

    redir_sel_e  w_sel;
    logic [31:0] w_target;
    flush_t      w_flush;
    logic        w_lu_stall;
    logic        w_halt_go;

    fetch_ctrl_redirect_arb #(
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_arb (
        .i_trap            (i_trap),
        .i_ex_br_taken     (i_ex_br_taken),
        .i_ex_br_target    (i_ex_br_target),
        .i_id_jump         (i_id_jump),
        .i_id_jump_target  (i_id_jump_target),
        .i_load_use_hazard (i_load_use_hazard),
        .i_pc4             (i_pc4),
        .o_sel             (w_sel),
        .o_target          (w_target),
        .o_flush           (w_flush),
        .o_lu_stall        (w_lu_stall)
    );

    // A trap in the same cycle as ebreak retirement takes precedence
    assign w_halt_go = i_halt_req && !i_trap;

    // Output decode and next-state selection; reset forces the quiet pattern
    always_comb begin
        o_pc_en       = 1'b0;
        o_npc         = i_pc;
        o_if_id_en    = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_ex_flush = 1'b0;
        o_halted      = 1'b0;
        w_state_nxt   = r_state;
        w_pend_ld     = 1'b0;
        w_pend_nxt    = w_target;

        if (!rst_n) begin
            o_npc         = RESET_VECTOR;
            o_if_id_flush = 1'b1;
            o_id_ex_flush = 1'b1;
            w_state_nxt   = ST_BOOT;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    o_pc_en       = 1'b1;
                    o_npc         = RESET_VECTOR;
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                    w_state_nxt   = ST_RUN;
                end

                ST_RUN: begin
                    if (w_halt_go) begin
                        o_if_id_flush = 1'b1;
                        o_id_ex_flush = 1'b1;
                        w_state_nxt   = ST_HALT;
                    end else if (w_sel != SEL_SEQ) begin
                        o_if_id_flush = w_flush.if_id;
                        o_id_ex_flush = w_flush.id_ex;
                        if (i_imem_ready) begin
                            o_pc_en    = 1'b1;
                            o_npc      = w_target;
                            o_if_id_en = 1'b1;
                        end else begin
                            // Fetch is busy: remember where to go once it returns
                            w_pend_ld   = 1'b1;
                            w_state_nxt = ST_PEND;
                        end
                    end else if (!i_imem_ready) begin
                        o_if_id_flush = 1'b1;
                    end else if (w_lu_stall) begin
                        o_id_ex_flush = 1'b1;
                    end else begin
                        o_pc_en    = 1'b1;
                        o_npc      = w_target;
                        o_if_id_en = 1'b1;
                    end
                end

                ST_PEND: begin
                    if (i_trap) begin
                        o_if_id_flush = 1'b1;
                        o_id_ex_flush = 1'b1;
                        if (i_imem_ready) begin
                            o_pc_en     = 1'b1;
                            o_npc       = TRAP_VECTOR;
                            o_if_id_en  = 1'b1;
                            w_state_nxt = ST_RUN;
                        end else begin
                            w_pend_ld  = 1'b1;
                            w_pend_nxt = TRAP_VECTOR;
                        end
                    end else if (w_halt_go) begin
                        o_if_id_flush = 1'b1;
                        o_id_ex_flush = 1'b1;
                        w_state_nxt   = ST_HALT;
                    end else if (i_imem_ready) begin
                        // Branches/jumps seen here are on the squashed path
                        o_pc_en       = 1'b1;
                        o_npc         = r_pend_pc;
                        o_if_id_en    = 1'b1;
                        o_if_id_flush = 1'b1;
                        w_state_nxt   = ST_RUN;
                    end else begin
                        o_if_id_flush = 1'b1;
                    end
                end

                ST_HALT: begin
                    o_if_id_flush = 1'b1;
                    o_id_ex_flush = 1'b1;
                    o_halted      = 1'b1;
                end

                default: begin
                    w_state_nxt = ST_BOOT;
                end
            endcase
        end
    end

    // State and parked redirect target; reset discards anything pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_BOOT;
            r_pend_pc <= RESET_VECTOR;
        end else begin
            r_state <= w_state_nxt;
            if (w_pend_ld) begin
                r_pend_pc <= w_pend_nxt;
            end
        end
    end

    // Count cycles where the PC is held, except while parked in HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= 32'd0;
        end else if (!o_pc_en && (r_state != ST_HALT) && (r_stall_cycles != STALL_MAX)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized run.
// Latency: expects same-cycle outputs, PC updates at the next rising edge.
// Backpressure: imem_ready and load_use_hazard are randomized by the bench.
module tb_fetch_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    // Behavioural model phases (bench-local, independent of the RTL encoding)
    localparam int PH_BOOT = 10;
    localparam int PH_GO   = 20;
    localparam int PH_WAIT = 30;
    localparam int PH_DONE = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_pc = 32'h0, i_pc4 = 32'h4;
    logic        i_imem_ready = 1'b0, i_load_use_hazard = 1'b0;
    logic        i_ex_br_taken = 1'b0, i_id_jump = 1'b0, i_trap = 1'b0, i_halt_req = 1'b0;
    logic [31:0] i_ex_br_target = 32'h0, i_id_jump_target = 32'h0;
    logic        o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_halted;
    logic [31:0] o_npc, o_stall_cycles;

    int total = 0;
    int bad   = 0;

    // Model state
    int          m_phase = PH_BOOT;
    logic [31:0] m_pend = RV;
    logic [31:0] m_stalls = 32'd0;
    logic [31:0] m_pc = 32'hDEAD_BEE0;
    // Model predictions for the current cycle
    logic        e_pc_en, e_if_id_en, e_ifl, e_exf, e_halted;
    logic [31:0] e_npc, e_stall, n_pend;
    int          n_phase;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_pc              (i_pc),
        .i_pc4             (i_pc4),
        .i_imem_ready      (i_imem_ready),
        .i_load_use_hazard (i_load_use_hazard),
        .i_ex_br_taken     (i_ex_br_taken),
        .i_ex_br_target    (i_ex_br_target),
        .i_id_jump         (i_id_jump),
        .i_id_jump_target  (i_id_jump_target),
        .i_trap            (i_trap),
        .i_halt_req        (i_halt_req),
        .o_pc_en           (o_pc_en),
        .o_npc             (o_npc),
        .o_if_id_en        (o_if_id_en),
        .o_if_id_flush     (o_if_id_flush),
        .o_id_ex_flush     (o_id_ex_flush),
        .o_halted          (o_halted),
        .o_stall_cycles    (o_stall_cycles)
    );

    // Evaluate the sequencing rules for the inputs currently applied
    task automatic predict();
        logic        redir, rf_if, rf_ex;
        logic [31:0] rt;
        e_pc_en = 0; e_if_id_en = 0; e_ifl = 0; e_exf = 0; e_halted = 0;
        e_npc = m_pc; n_phase = m_phase; n_pend = m_pend;
        e_stall = rst_n ? m_stalls : 32'd0;
        redir = 1; rt = 0; rf_if = 0; rf_ex = 0;
        if (i_trap)                                 begin rt = TV; rf_if = 1; rf_ex = 1; end
        else if (i_ex_br_taken)                     begin rt = i_ex_br_target; rf_if = 1; rf_ex = 1; end
        else if (i_id_jump && !i_load_use_hazard)   begin rt = i_id_jump_target; rf_if = 1; end
        else redir = 0;
        if (!rst_n) begin
            e_npc = RV; e_ifl = 1; e_exf = 1;
        end else if (m_phase == PH_DONE) begin
            e_ifl = 1; e_exf = 1; e_halted = 1;
        end else if (m_phase == PH_BOOT) begin
            e_pc_en = 1; e_npc = RV; e_ifl = 1; e_exf = 1; n_phase = PH_GO;
        end else if (m_phase == PH_WAIT) begin
            if (i_trap && i_imem_ready) begin
                e_pc_en = 1; e_npc = TV; e_ifl = 1; e_exf = 1; e_if_id_en = 1; n_phase = PH_GO;
            end else if (i_trap) begin
                e_ifl = 1; e_exf = 1; n_pend = TV;
            end else if (i_halt_req) begin
                e_ifl = 1; e_exf = 1; n_phase = PH_DONE;
            end else if (i_imem_ready) begin
                e_pc_en = 1; e_npc = m_pend; e_ifl = 1; e_if_id_en = 1; n_phase = PH_GO;
            end else begin
                e_ifl = 1;
            end
        end else begin
            if (i_halt_req && !i_trap) begin
                e_ifl = 1; e_exf = 1; n_phase = PH_DONE;
            end else if (redir) begin
                e_ifl = rf_if; e_exf = rf_ex;
                if (i_imem_ready) begin e_pc_en = 1; e_npc = rt; e_if_id_en = 1; end
                else begin n_pend = rt; n_phase = PH_WAIT; end
            end else if (!i_imem_ready) begin
                e_ifl = 1;
            end else if (i_load_use_hazard) begin
                e_exf = 1;
            end else begin
                e_pc_en = 1; e_npc = m_pc + 32'd4; e_if_id_en = 1;
            end
        end
    endtask

    // Commit the model (and the bench-side PC register) at the clock edge
    task automatic advance();
        if (!rst_n) begin
            m_phase = PH_BOOT; m_pend = RV; m_stalls = 0;
        end else begin
            if (!e_pc_en && m_phase != PH_DONE && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
            if (e_pc_en) m_pc = e_npc;
            m_phase = n_phase; m_pend = n_pend;
        end
    endtask

    // One clock: predict, edge, commit, then present the new PC at the falling edge
    task automatic tick();
        predict();
        @(posedge clk);
        advance();
        @(negedge clk);
        i_pc = m_pc; i_pc4 = m_pc + 32'd4;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        m_pc = pc; i_pc = pc; i_pc4 = pc + 32'd4;
    endtask

    task automatic clear_inputs();
        i_load_use_hazard = 0; i_ex_br_taken = 0; i_id_jump = 0; i_trap = 0; i_halt_req = 0;
        i_ex_br_target = 0; i_id_jump_target = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; clear_inputs(); i_imem_ready = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (o_pc_en !== 1'b0) begin bad++; $display("FAIL rst_pc_en got=%b exp=0", o_pc_en); end
            total++; if (o_npc !== RV) begin bad++; $display("FAIL rst_npc got=%h exp=%h", o_npc, RV); end
            total++; if ({o_if_id_en, o_if_id_flush, o_id_ex_flush, o_halted} !== 4'b0110) begin
                bad++; $display("FAIL rst_ctl got=%b exp=0110", {o_if_id_en, o_if_id_flush, o_id_ex_flush, o_halted}); end
            total++; if (o_stall_cycles !== 32'd0) begin bad++; $display("FAIL rst_stall got=%0d exp=0", o_stall_cycles); end
            tick();
        end
    endtask

    task automatic test_boot_seq();
        rst_n = 1; clear_inputs(); i_imem_ready = 1;
        #1;
        total++; if ({o_pc_en, o_npc} !== {1'b1, RV}) begin bad++; $display("FAIL boot_npc got=%b/%h exp=1/%h", o_pc_en, o_npc, RV); end
        total++; if ({o_if_id_en, o_if_id_flush, o_id_ex_flush} !== 3'b011) begin
            bad++; $display("FAIL boot_ctl got=%b exp=011", {o_if_id_en, o_if_id_flush, o_id_ex_flush}); end
        tick();
        for (int k = 1; k <= 5; k++) begin
            #1;
            total++; if ({o_pc_en, o_npc} !== {1'b1, 32'(4 * k)}) begin
                bad++; $display("FAIL seq_npc got=%b/%h exp=1/%h", o_pc_en, o_npc, 32'(4 * k)); end
            total++; if ({o_if_id_en, o_if_id_flush, o_id_ex_flush} !== 3'b100) begin
                bad++; $display("FAIL seq_ctl got=%b exp=100", {o_if_id_en, o_if_id_flush, o_id_ex_flush}); end
            tick();
        end
    endtask

    task automatic test_branch_priority();
        set_pc(32'h20); i_imem_ready = 1;
        i_ex_br_taken = 1; i_ex_br_target = 32'h80; i_id_jump = 1; i_id_jump_target = 32'h40;
        #1;
        total++; if ({o_pc_en, o_npc, o_if_id_flush, o_id_ex_flush} !== {1'b1, 32'h80, 2'b11}) begin
            bad++; $display("FAIL br_over_jump got=%b/%h/%b%b exp=1/80/11", o_pc_en, o_npc, o_if_id_flush, o_id_ex_flush); end
        tick();
        i_ex_br_taken = 0;
        #1;
        total++; if ({o_pc_en, o_npc, o_if_id_flush, o_id_ex_flush} !== {1'b1, 32'h40, 2'b10}) begin
            bad++; $display("FAIL jump_only got=%b/%h/%b%b exp=1/40/10", o_pc_en, o_npc, o_if_id_flush, o_id_ex_flush); end
        tick();
        i_trap = 1; i_ex_br_taken = 1; i_load_use_hazard = 1;
        #1;
        total++; if ({o_pc_en, o_npc, o_if_id_flush, o_id_ex_flush} !== {1'b1, TV, 2'b11}) begin
            bad++; $display("FAIL trap_over_br got=%b/%h/%b%b exp=1/%h/11", o_pc_en, o_npc, o_if_id_flush, o_id_ex_flush, TV); end
        tick();
        i_trap = 0; i_ex_br_taken = 0;
        #1;
        total++; if ({o_pc_en, o_if_id_flush, o_id_ex_flush} !== 3'b001) begin
            bad++; $display("FAIL lu_blocks_jump got=%b exp=001", {o_pc_en, o_if_id_flush, o_id_ex_flush}); end
        tick();
        clear_inputs();
    endtask

    task automatic test_load_use();
        logic [31:0] s0;
        set_pc(32'h10); i_imem_ready = 1; i_load_use_hazard = 1;
        s0 = m_stalls;
        #1;
        total++; if ({o_pc_en, o_if_id_en, o_id_ex_flush} !== 3'b001) begin
            bad++; $display("FAIL lu_ctl got=%b exp=001", {o_pc_en, o_if_id_en, o_id_ex_flush}); end
        tick();
        i_load_use_hazard = 0;
        #1;
        total++; if (o_stall_cycles !== s0 + 32'd1) begin bad++; $display("FAIL lu_stall got=%0d exp=%0d", o_stall_cycles, s0 + 32'd1); end
        total++; if ({o_pc_en, o_npc} !== {1'b1, 32'h14}) begin bad++; $display("FAIL lu_resume got=%b/%h exp=1/14", o_pc_en, o_npc); end
        tick();
    endtask

    task automatic test_pending();
        set_pc(32'h44); i_imem_ready = 0; i_ex_br_taken = 1; i_ex_br_target = 32'h200;
        #1;
        total++; if ({o_pc_en, o_if_id_flush, o_id_ex_flush} !== 3'b011) begin
            bad++; $display("FAIL pend_enter got=%b exp=011", {o_pc_en, o_if_id_flush, o_id_ex_flush}); end
        tick();
        clear_inputs();
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin i_id_jump = 1; i_id_jump_target = 32'h300; end
            #1;
            total++; if ({o_pc_en, o_if_id_flush} !== 2'b01) begin bad++; $display("FAIL pend_hold got=%b exp=01", {o_pc_en, o_if_id_flush}); end
            tick();
        end
        clear_inputs(); i_imem_ready = 1;
        #1;
        total++; if ({o_pc_en, o_npc, o_if_id_flush} !== {1'b1, 32'h200, 1'b1}) begin
            bad++; $display("FAIL pend_apply got=%b/%h/%b exp=1/200/1", o_pc_en, o_npc, o_if_id_flush); end
        tick();
    endtask

    task automatic test_pend_trap();
        i_imem_ready = 0; i_ex_br_taken = 1; i_ex_br_target = 32'h200;
        tick();
        i_ex_br_taken = 0; i_trap = 1;
        #1;
        total++; if ({o_pc_en, o_if_id_flush, o_id_ex_flush} !== 3'b011) begin
            bad++; $display("FAIL pend_trap got=%b exp=011", {o_pc_en, o_if_id_flush, o_id_ex_flush}); end
        tick();
        i_trap = 0; i_ex_br_taken = 1; i_ex_br_target = 32'h280;
        tick();
        clear_inputs(); i_imem_ready = 1;
        #1;
        total++; if ({o_pc_en, o_npc} !== {1'b1, TV}) begin bad++; $display("FAIL pend_trap_apply got=%b/%h exp=1/%h", o_pc_en, o_npc, TV); end
        tick();
    endtask

    task automatic test_halt();
        logic [31:0] s0;
        set_pc(32'h30); i_imem_ready = 1; i_halt_req = 1;
        #1;
        total++; if ({o_pc_en, o_if_id_flush, o_id_ex_flush} !== 3'b011) begin
            bad++; $display("FAIL halt_enter got=%b exp=011", {o_pc_en, o_if_id_flush, o_id_ex_flush}); end
        tick();
        s0 = m_stalls;
        for (int k = 0; k < 5; k++) begin
            i_halt_req = 0; i_trap = 1'($urandom); i_ex_br_taken = 1'($urandom); i_imem_ready = 1'($urandom);
            #1;
            total++; if ({o_halted, o_pc_en, o_if_id_en} !== 3'b100) begin
                bad++; $display("FAIL halt_hold got=%b exp=100", {o_halted, o_pc_en, o_if_id_en}); end
            total++; if (o_stall_cycles !== s0) begin bad++; $display("FAIL halt_stall got=%0d exp=%0d", o_stall_cycles, s0); end
            tick();
        end
        clear_inputs(); i_imem_ready = 1; rst_n = 0;
        #1;
        total++; if ({o_halted, o_pc_en, o_npc, o_stall_cycles} !== {2'b00, RV, 32'd0}) begin
            bad++; $display("FAIL halt_rst got=%b%b/%h/%0d exp=00/%h/0", o_halted, o_pc_en, o_npc, o_stall_cycles, RV); end
        tick();
        rst_n = 1;
        #1;
        total++; if ({o_halted, o_pc_en, o_npc} !== {2'b01, RV}) begin
            bad++; $display("FAIL halt_reboot got=%b%b/%h exp=01/%h", o_halted, o_pc_en, o_npc, RV); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            rst_n             = ($urandom_range(0, 149) != 0);
            i_imem_ready      = ($urandom_range(0, 3) != 0);
            i_load_use_hazard = ($urandom_range(0, 5) == 0);
            i_ex_br_taken     = ($urandom_range(0, 7) == 0);
            i_id_jump         = ($urandom_range(0, 7) == 0);
            i_trap            = ($urandom_range(0, 19) == 0);
            i_halt_req        = ($urandom_range(0, 59) == 0);
            i_ex_br_target    = {$urandom_range(0, 32'h3FFF), 2'b00};
            i_id_jump_target  = {$urandom_range(0, 32'h3FFF), 2'b00};
            #1;
            predict();
            total++; if (o_pc_en !== e_pc_en) begin bad++; $display("FAIL rnd_pc_en n=%0d got=%b exp=%b", n, o_pc_en, e_pc_en); end
            if (e_pc_en || !rst_n) begin
                total++; if (o_npc !== e_npc) begin bad++; $display("FAIL rnd_npc n=%0d got=%h exp=%h", n, o_npc, e_npc); end
            end
            total++; if (o_if_id_en !== e_if_id_en) begin bad++; $display("FAIL rnd_if_id_en n=%0d got=%b exp=%b", n, o_if_id_en, e_if_id_en); end
            total++; if (o_if_id_flush !== e_ifl) begin bad++; $display("FAIL rnd_if_id_flush n=%0d got=%b exp=%b", n, o_if_id_flush, e_ifl); end
            total++; if (o_id_ex_flush !== e_exf) begin bad++; $display("FAIL rnd_id_ex_flush n=%0d got=%b exp=%b", n, o_id_ex_flush, e_exf); end
            total++; if (o_halted !== e_halted) begin bad++; $display("FAIL rnd_halted n=%0d got=%b exp=%b", n, o_halted, e_halted); end
            total++; if (o_stall_cycles !== e_stall) begin bad++; $display("FAIL rnd_stall n=%0d got=%0d exp=%0d", n, o_stall_cycles, e_stall); end
            tick();
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_boot_seq();
        test_branch_priority();
        test_load_use();
        test_pending();
        test_pend_trap();
        test_halt();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Next-PC sequencer for the pipelined core's fetch stage. Drives the PC register's enable and next-address inputs from its current PC and PC+4, arbitrating between trap, EX branch redirect, ID jump and sequential fetch. Holds PC during instruction-memory waits and load-use stalls, and latches a redirect that arrives while fetch is blocked. Generates IF/ID and ID/EX flush/enable controls.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- TRAP_VECTOR, 32'h0000_0100, redirect target on trap
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- pc  in  32  current PC from PC register
- pc4  in  32  pc+4 from PC register
- imem_ready  in  1  instruction memory returns fetch data this cycle
- load_use_hazard  in  1  ID instruction must stall one cycle
- ex_br_taken  in  1  EX resolved taken branch / jalr
- ex_br_target  in  32  EX redirect address
- id_jump  in  1  ID decoded jal
- id_jump_target  in  32  ID jump address
- trap  in  1  illegal instruction / ecall from EX
- halt_req  in  1  ebreak retired; stop fetch
- pc_en  out  1  PC register load enable
- npc  out  32  PC register next value
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID insert bubble
- id_ex_flush  out  1  ID/EX insert bubble
- halted  out  1  block in HALT
- stall_cycles  out  32  saturating count of cycles with pc_en=0 outside HALT

## Operation
- States: BOOT, RUN, PEND, HALT (2-bit encoding). Registers: state, pend_pc[31:0], stall_cycles.
- Redirect priority: trap > ex_br_taken > id_jump > sequential (pc4). trap/ex_br_taken assert both flushes; id_jump asserts if_id_flush only.
- load_use_hazard blocks only sequential fetch and id_jump; trap and ex_br_taken override it (flush kills the stalled consumer).
- BOOT: pc_en=1, npc=RESET_VECTOR, both flushes=1, if_id_en=0; next state RUN unconditionally.
- RUN, imem_ready=1: winning redirect → pc_en=1, npc=target; else if load_use_hazard → pc_en=0, if_id_en=0, id_ex_flush=1; else pc_en=1, npc=pc4, if_id_en=1.
- RUN, imem_ready=0 with redirect: flushes asserted this cycle, pend_pc←target, pc_en=0, go PEND. Without redirect: pc_en=0, if_id_en=0, if_id_flush=1.
- PEND: pc_en=0 until imem_ready=1, then pc_en=1, npc=pend_pc, if_id_flush=1, go RUN. A trap in PEND overwrites pend_pc with TRAP_VECTOR and flushes; branch/jump in PEND are ignored (already squashed).
- halt_req (RUN or PEND, no trap same cycle): pc_en=0, both flushes=1, go HALT. HALT: pc_en=0, if_id_en=0, flushes=1; exit only by reset. trap same cycle as halt_req: trap wins, halt_req dropped.
- stall_cycles increments when pc_en=0 and state≠HALT; saturates at 32'hFFFF_FFFF.

## Timing
- All outputs combinational from state/inputs; redirect has zero-cycle controller latency (PC updates on the next clk edge).
- During rst_n=0: state=BOOT, pend_pc=RESET_VECTOR, stall_cycles=0; outputs pc_en=0, npc=RESET_VECTOR, if_id_en=0, flushes=1, halted=0.
- Reset deassert: first edge is BOOT (PC loads RESET_VECTOR), sequential fetch from the second edge.
- Reset asserted mid-PEND: pending redirect discarded; restart at RESET_VECTOR.
- Pending redirect applied on the first edge where imem_ready=1, never earlier.

## Structure
- Shared package: state enum, priority-select encoding, RESET_VECTOR/TRAP_VECTOR defaults, flush-cause constants.
- One natural sub-module: redirect_arb (combinational priority select of target and flush flags). FSM, pend_pc and counter stay in the top.

## Test plan
- Release reset, imem_ready=1 → edge 1 npc=0 pc_en=1 flushes=1; edge 2 npc=4; sequential 0,4,8,…
- RUN at pc=0x20, ex_br_taken with target 0x80 and id_jump with target 0x40 together → npc=0x80, if_id_flush=id_ex_flush=1.
- load_use_hazard one cycle at pc=0x10 → pc_en=0, id_ex_flush=1, stall_cycles+1; next cycle npc=0x14.
- imem_ready=0 for 3 cycles, ex_br_taken target 0x200 in first → state PEND, pc_en=0 for 3 cycles, npc=0x200 when ready.
- In PEND (pend_pc=0x200) assert trap → pend_pc=0x100; on ready npc=0x100.
- halt_req at pc=0x30 → halted=1, pc_en=0 indefinitely, stall_cycles frozen; rst_n pulse → BOOT, npc=0.
